// File: rtl/mem_responder.sv
// mem_responder: responder for the CPU memory request bus (en/ren/wen/addr/din/dout).
// It owns the unified instruction/data word array. CPU reads complete after a fixed
// latency and CPU writes complete in one cycle. A lower-priority inference readout
// port returns the low 16 bits of a word for the seven-segment path.

module mem_responder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MEM_DEPTH  = 8192,
  parameter int READ_LAT   = 3,
  parameter int INFER_BASE = 6300
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              busy,
  output logic              oob,
  input  logic              infer_req,
  input  logic [9:0]        infer_addr,
  output logic [15:0]       infer_data,
  output logic              infer_valid
);

  // The counter only has to hold READ_LAT-1. Keep it at least one bit wide so that
  // READ_LAT=1 still elaborates.
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  // Array index width. Addresses are range-checked before their low bits are used.
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // The depth is held one bit wider than an address so MEM_DEPTH == 2**ADDR_W still works.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    INF_WAIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Control strobes decoded from the state and the request inputs.
  logic wr_accept;
  logic rd_accept;
  logic inf_accept;
  logic rd_done;
  logic inf_done;

  logic              cnt_zero;
  logic              addr_in_range;
  logic              lat_in_range;
  logic [ADDR_W-1:0] infer_full_addr;
  logic [IDX_W-1:0]  addr_idx;
  logic [IDX_W-1:0]  lat_idx;

  assign cnt_zero        = (cnt == '0);
  assign addr_in_range   = ({1'b0, addr} < DEPTH_X);
  assign lat_in_range    = ({1'b0, lat_addr} < DEPTH_X);
  assign infer_full_addr = ADDR_W'(INFER_BASE) + ADDR_W'(infer_addr);
  assign addr_idx        = addr[IDX_W-1:0];
  assign lat_idx         = lat_addr[IDX_W-1:0];

  // State register: an asynchronous reset aborts any read in flight.
  // NOTE: sequential state uses non-blocking (<=) so that every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Writes stay in IDLE. A completed read always returns to IDLE.
  always_comb begin
    // NOTE: assigning a default first keeps every path assigned, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rd_accept) begin
          state_nxt = RD_WAIT;
        end else if (inf_accept) begin
          state_nxt = INF_WAIT;
        end
      end
      RD_WAIT:  if (cnt_zero) state_nxt = IDLE;
      INF_WAIT: if (cnt_zero) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output and strobe decode. In IDLE, a write beats a read, and any CPU request beats
  // an inference request. While waiting, all requests are ignored and are not queued.
  always_comb begin
    wr_accept  = 1'b0;
    rd_accept  = 1'b0;
    inf_accept = 1'b0;
    rd_done    = 1'b0;
    inf_done   = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && wen) begin
          wr_accept = 1'b1;
        end else if (en && ren) begin
          rd_accept = 1'b1;
        end else if (!en && infer_req) begin
          inf_accept = 1'b1;
        end
      end
      RD_WAIT: begin
        busy    = 1'b1;
        rd_done = cnt_zero;
      end
      INF_WAIT: begin
        busy     = 1'b1;
        inf_done = cnt_zero;
      end
      default: ;
    endcase
  end

  // Latency counter and latched read address. Loaded on acceptance, then counted down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      lat_addr <= '0;
    end else if (rd_accept) begin
      cnt      <= CNT_INIT;
      lat_addr <= addr;
    end else if (inf_accept) begin
      cnt      <= CNT_INIT;
      lat_addr <= infer_full_addr;
    end else if (state != IDLE && !cnt_zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Word array. Writes land at the accepting edge. Out-of-range writes are dropped.
  // NOTE: the array has no reset; contents survive reset and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (reset && wr_accept && addr_in_range) begin
      mem[addr_idx] <= din;
    end
  end

  // Read-return registers. Data is sampled at the completion edge, and out-of-range
  // reads return zero. The pulses last exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout        <= '0;
      rvalid      <= 1'b0;
      oob         <= 1'b0;
      infer_data  <= '0;
      infer_valid <= 1'b0;
    end else begin
      rvalid      <= rd_done;
      infer_valid <= inf_done;
      oob         <= (wr_accept && !addr_in_range) || (rd_done && !lat_in_range);
      if (rd_done) begin
        dout <= lat_in_range ? mem[lat_idx] : '0;
      end
      if (inf_done) begin
        infer_data <= lat_in_range ? mem[lat_idx][15:0] : 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios followed by random traffic. A transaction-level
// model tracks the expected outputs, and a compare process checks them on every cycle.

module tb_mem_responder;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int MEM_DEPTH  = 8192;
  localparam int READ_LAT   = 3;
  localparam int INFER_BASE = 6300;

  logic              clk;
  logic              reset;
  logic              en, ren, wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rvalid, busy, oob;
  logic              infer_req;
  logic [9:0]        infer_addr;
  logic [15:0]       infer_data;
  logic              infer_valid;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
    .READ_LAT(READ_LAT), .INFER_BASE(INFER_BASE)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .ren(ren), .wen(wen), .addr(addr), .din(din),
    .dout(dout), .rvalid(rvalid), .busy(busy), .oob(oob), .infer_req(infer_req),
    .infer_addr(infer_addr), .infer_data(infer_data), .infer_valid(infer_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model holds known words and at most one pending read, stamped with the cycle
  // in which it must complete.
  logic [31:0] model_mem [int];
  bit          pend, pend_inf;
  int          pend_addr;
  longint      pend_done, cyc;
  logic [31:0] e_dout;
  logic [15:0] e_idata;
  bit          e_dout_k, e_idata_k;
  bit          e_rvalid, e_oob, e_busy, e_iv;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend = 0; cyc = 0;
      e_dout = '0; e_idata = '0; e_dout_k = 1; e_idata_k = 1;
      e_rvalid = 0; e_oob = 0; e_busy = 0; e_iv = 0;
    end else begin
      cyc++;
      e_rvalid = 0; e_oob = 0; e_iv = 0;
      if (pend) begin
        if (cyc == pend_done) begin
          bit inr;
          inr  = pend_addr < MEM_DEPTH;
          pend = 0;
          if (pend_inf) begin
            e_iv = 1;
            if (!inr) begin e_idata = '0; e_idata_k = 1; end
            else if (model_mem.exists(pend_addr)) begin
              e_idata = model_mem[pend_addr][15:0]; e_idata_k = 1;
            end else e_idata_k = 0;
          end else begin
            e_rvalid = 1;
            e_oob    = !inr;
            if (!inr) begin e_dout = '0; e_dout_k = 1; end
            else if (model_mem.exists(pend_addr)) begin
              e_dout = model_mem[pend_addr]; e_dout_k = 1;
            end else e_dout_k = 0;
          end
        end
      end else if (en && wen) begin
        if (int'(addr) < MEM_DEPTH) model_mem[int'(addr)] = din;
        else e_oob = 1;
      end else if (en && ren) begin
        pend = 1; pend_inf = 0; pend_addr = int'(addr); pend_done = cyc + READ_LAT;
      end else if (!en && infer_req) begin
        pend = 1; pend_inf = 1;
        pend_addr = (INFER_BASE + int'(infer_addr)) & 32'hFFFF;
        pend_done = cyc + READ_LAT;
      end
      e_busy = pend;
    end
  end

  // Compare process: check every output against the model while out of reset.
  always @(negedge clk) begin
    if (reset) begin
      check("rvalid", {31'b0, rvalid}, {31'b0, e_rvalid});
      check("busy", {31'b0, busy}, {31'b0, e_busy});
      check("oob", {31'b0, oob}, {31'b0, e_oob});
      check("infer_valid", {31'b0, infer_valid}, {31'b0, e_iv});
      if (e_dout_k) check("dout", dout, e_dout);
      if (e_idata_k) check("infer_data", {16'b0, infer_data}, {16'b0, e_idata});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic e, input logic r, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic ir, input logic [9:0] ia);
    en = e; ren = r; wen = w; addr = a; din = d; infer_req = ir; infer_addr = ia;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 0, '0);
  endtask

  task automatic write_word(input logic [15:0] a, input logic [31:0] d);
    drive(1, 0, 1, a, d, 0, '0);
    @(negedge clk);
    idle();
  endtask

  // Wait for a pulse on rvalid (which=0) or infer_valid (which=1). lat=0 on timeout.
  task automatic wait_pulse(input int which, input int max_cyc, output int lat);
    lat = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if ((which == 0 && rvalid) || (which == 1 && infer_valid)) begin
        lat = k;
        break;
      end
    end
  endtask

  // Issue one CPU read. The task returns at the negedge where rvalid is seen.
  task automatic do_read(input logic [15:0] a, output int lat);
    drive(1, 1, 0, a, '0, 0, '0);
    @(negedge clk);
    idle();
    wait_pulse(0, 8, lat);
  endtask

  logic [31:0] init_val [16];

  initial begin
    int lat, cnt;
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    check("rst_dout", dout, 32'h0);
    check("rst_pulses", {28'b0, rvalid, busy, oob, infer_valid}, 32'h0);
    check("rst_idata", {16'b0, infer_data}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Preload every word that later reads can reach.
    for (int i = 0; i < 16; i++) begin
      init_val[i] = $urandom;
      write_word(16'(i), init_val[i]);
      write_word(16'(INFER_BASE + 1 + i), $urandom);
    end
    write_word(16'(INFER_BASE), 32'hABCD1234);
    write_word(16'd8191, 32'h5A5A0001);

    // 1: write then read, latency and busy window
    write_word(16'd5, 32'hDEADBEEF);
    drive(1, 1, 0, 16'd5, '0, 0, '0);
    @(negedge clk);
    check("t1_busy_acc", {31'b0, busy}, 32'd1);
    idle();
    wait_pulse(0, 8, lat);
    check("t1_latency", lat, READ_LAT);
    check("t1_dout", dout, 32'hDEADBEEF);
    check("t1_model_dout", e_dout, 32'hDEADBEEF);
    check("t1_busy_done", {31'b0, busy}, 32'd0);

    // 2: out-of-range read and write
    do_read(16'hFFFF, lat);
    check("t2_rd_lat", lat, READ_LAT);
    check("t2_rd_oob", {31'b0, oob}, 32'd1);
    check("t2_rd_dout", dout, 32'h0);
    drive(1, 0, 1, 16'hFFFF, 32'h77777777, 0, '0);
    @(negedge clk);
    check("t2_wr_oob", {31'b0, oob}, 32'd1);
    idle();
    @(negedge clk);
    check("t2_oob_clear", {31'b0, oob}, 32'd0);
    do_read(16'd8191, lat);
    check("t2_alias_word", dout, 32'h5A5A0001);

    // 3: arbitration, CPU read wins, then infer of word INFER_BASE
    drive(1, 1, 0, 16'd2, '0, 1, 10'd0);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, 1, 10'd0);
    wait_pulse(0, 8, lat);
    check("t3_cpu_first", lat, READ_LAT);
    check("t3_no_iv", {31'b0, infer_valid}, 32'd0);
    check("t3_dout", dout, init_val[2]);
    wait_pulse(1, 10, lat);
    check("t3_inf_lat", lat, READ_LAT + 1);
    check("t3_idata", {16'b0, infer_data}, 32'h1234);
    check("t3_model_idata", {16'b0, e_idata}, 32'h1234);
    idle();

    // 4: writes while busy are dropped, and a write beats a read
    drive(1, 1, 0, 16'd3, '0, 0, '0);
    @(negedge clk);
    drive(1, 0, 1, 16'd4, 32'h11112222, 0, '0);
    repeat (2) @(negedge clk);
    idle();
    wait_pulse(0, 8, lat);
    check("t4_rd3", dout, init_val[3]);
    do_read(16'd4, lat);
    check("t4_drop", dout, init_val[4]);
    drive(1, 1, 1, 16'd6, 32'hCAFEF00D, 0, '0);
    @(negedge clk);
    check("t4_wr_not_busy", {31'b0, busy}, 32'd0);
    idle();
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (rvalid) cnt++;
    end
    check("t4_no_rvalid", cnt, 0);
    do_read(16'd6, lat);
    check("t4_wr_done", dout, 32'hCAFEF00D);

    // 5: reset mid-read
    drive(1, 1, 0, 16'd5, '0, 0, '0);
    @(negedge clk);
    idle();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t5_async_dout", dout, 32'h0);
    check("t5_async_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid) cnt++;
    end
    check("t5_no_rvalid", cnt, 0);
    do_read(16'd5, lat);
    check("t5_kept", dout, 32'hDEADBEEF);

    // Random traffic. The compare process checks every cycle.
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic [15:0] a;
      sel = $urandom_range(0, 19);
      if (sel < 16) a = 16'(sel);
      else if (sel == 16) a = 16'hFFFF;
      else if (sel == 17) a = 16'd8192;
      else if (sel == 18) a = 16'd8191;
      else a = 16'(INFER_BASE + $urandom_range(0, 15));
      drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 3) == 0), a, $urandom,
            logic'($urandom_range(0, 1)), 10'($urandom_range(0, 15)));
      @(negedge clk);
    end
    idle();
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
